// File: rtl/mrisc_ctrl_pkg.sv
// Shared encodings for the Mini RISC multi-cycle control sequencer:
// opcodes, sequencer states and PC source selects.
package mrisc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_LD    = 6'h02;
  localparam logic [5:0] OP_ST    = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h05;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter.
// Optional macro MRISC_ILLEGAL_TRAP_EN: illegal opcodes halt with sticky trap.
module multicycle_control_fsm
  import mrisc_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                pc_we,
  output logic                ir_we,
  output logic                rf_we,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                alu_src_imm,
  output logic                wb_sel,
  output logic                rd_sel,
  output logic [1:0]          pc_src,
  output logic                halted,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired,
  output state_e              dbg_state
);

  // Memory handshake: mem_req with addr_sel/mem_we stays constant until a
  // cycle where mem_ready=1; that cycle completes the access and advances.
  state_e              r_state;
  state_e              w_next;
  logic                w_retire;
  logic [RETIRE_W-1:0] r_retired;
`ifdef MRISC_ILLEGAL_TRAP_EN
  logic                r_trap;
  logic                w_trap_set;
`endif

  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    alu_src_imm = 1'b0;
    wb_sel      = 1'b0;
    rd_sel      = 1'b0;
    pc_src      = PC_SRC_SEQ;
`ifdef MRISC_ILLEGAL_TRAP_EN
    w_trap_set  = 1'b0;
`endif
    // Gating on rst_n makes an asserted reset drop the request immediately.
    if (rst_n) begin
      case (r_state)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we  = 1'b1;
            pc_we  = 1'b1;
            w_next = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (opcode == OP_HALT) begin
            w_next   = ST_HALTED;
            w_retire = 1'b1;
          end else if (opcode == OP_J) begin
            pc_we    = 1'b1;
            pc_src   = PC_SRC_JUMP;
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end else if (!is_legal_op(opcode)) begin
`ifdef MRISC_ILLEGAL_TRAP_EN
            w_next     = ST_HALTED;
            w_trap_set = 1'b1;
`else
            w_next   = ST_FETCH;
            w_retire = 1'b1;
`endif
          end else begin
            w_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_src_imm = (opcode == OP_ADDI) || (opcode == OP_LD) || (opcode == OP_ST);
          if (opcode == OP_BEQ) begin
            if (alu_zero) begin
              pc_we  = 1'b1;
              pc_src = PC_SRC_BRANCH;
            end
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end else if ((opcode == OP_LD) || (opcode == OP_ST)) begin
            w_next = ST_MEM;
          end else begin
            w_next = ST_WB;
          end
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OP_ST);
          if (mem_ready) begin
            if (opcode == OP_ST) begin
              w_next   = ST_FETCH;
              w_retire = 1'b1;
            end else begin
              w_next = ST_WB;
            end
          end
        end
        ST_WB: begin
          rf_we    = 1'b1;
          wb_sel   = (opcode == OP_LD);
          rd_sel   = (opcode == OP_RTYPE);
          w_next   = ST_FETCH;
          w_retire = 1'b1;
        end
        ST_HALTED: w_next = ST_HALTED;
        default:   w_next = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
    end
  end

`ifdef MRISC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_trap <= 1'b0;
    else if (w_trap_set) r_trap <= 1'b1;
  end
  assign trap = r_trap;
`else
  assign trap = 1'b0;
`endif

  assign halted    = (r_state == ST_HALTED);
  assign retired   = r_retired;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected output records
// go into a queue and a monitor compares them whenever the DUT asserts an output.
module tb_multicycle_control_fsm;
  import mrisc_ctrl_pkg::*;

  localparam int RW = 4;
  localparam int EW = 32 + 13 + RW;

  // {pc_we, ir_we, rf_we, mem_req, mem_we, addr_sel, alu_src_imm, wb_sel, rd_sel, pc_src[1:0], halted, trap}
  localparam logic [12:0] O_NONE       = 13'b0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] O_FETCH_WAIT = 13'b0_0_0_1_0_0_0_0_0_00_0_0;
  localparam logic [12:0] O_FETCH_RDY  = 13'b1_1_0_1_0_0_0_0_0_00_0_0;
  localparam logic [12:0] O_J          = 13'b1_0_0_0_0_0_0_0_0_10_0_0;
  localparam logic [12:0] O_EX_IMM     = 13'b0_0_0_0_0_0_1_0_0_00_0_0;
  localparam logic [12:0] O_BEQ_T      = 13'b1_0_0_0_0_0_0_0_0_01_0_0;
  localparam logic [12:0] O_MEM_LD     = 13'b0_0_0_1_0_1_0_0_0_00_0_0;
  localparam logic [12:0] O_MEM_ST     = 13'b0_0_0_1_1_1_0_0_0_00_0_0;
  localparam logic [12:0] O_WB_R       = 13'b0_0_1_0_0_0_0_0_1_00_0_0;
  localparam logic [12:0] O_WB_I       = 13'b0_0_1_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] O_WB_LD      = 13'b0_0_1_0_0_0_0_1_0_00_0_0;
  localparam logic [12:0] O_HALT       = 13'b0_0_0_0_0_0_0_0_0_00_1_0;
  localparam logic [12:0] O_TRAP       = 13'b0_0_0_0_0_0_0_0_0_00_1_1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          alu_zero;
  logic          mem_ready;
  logic          pc_we, ir_we, rf_we, mem_req, mem_we, addr_sel;
  logic          alu_src_imm, wb_sel, rd_sel, halted, trap;
  logic [1:0]    pc_src;
  logic [RW-1:0] retired;
  state_e        dbg_state;

  logic [31:0]   cyc = '0;
  logic [RW-1:0] exp_ret;
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  wire [12:0] w_act = {pc_we, ir_we, rf_we, mem_req, mem_we, addr_sel, alu_src_imm,
                       wb_sel, rd_sel, pc_src, halted, trap};
  wire        w_ev  = pc_we | ir_we | rf_we | mem_req | alu_src_imm | halted | trap;

  multicycle_control_fsm #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .alu_src_imm(alu_src_imm), .wb_sel(wb_sel), .rd_sel(rd_sel),
    .pc_src(pc_src), .halted(halted), .trap(trap), .retired(retired), .dbg_state(dbg_state)
  );

  // Clock and cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock cycle of stimulus; ev pushes the record the monitor must see.
  task automatic drive(input logic [5:0] op, input logic z, input logic rdy,
                       input logic ev, input logic [12:0] eo);
    @(posedge clk); #1;
    opcode = op; alu_zero = z; mem_ready = rdy;
    if (ev) exp_q.push_back({cyc, eo, exp_ret});
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    for (int i = 0; i < fw; i++) drive(op, z, 1'b0, 1'b1, O_FETCH_WAIT);
    drive(op, z, 1'b1, 1'b1, O_FETCH_RDY);
    if (op == OP_J) begin
      drive(op, z, 1'b1, 1'b1, O_J);
      exp_ret = exp_ret + 1'b1;
    end else if (op == OP_HALT) begin
      drive(op, z, 1'b1, 1'b0, O_NONE);
      exp_ret = exp_ret + 1'b1;
      for (int i = 0; i < 3; i++) drive(op, z, 1'b1, 1'b1, O_HALT);
    end else if (!is_legal_op(op)) begin
      drive(op, z, 1'b1, 1'b0, O_NONE);
`ifdef MRISC_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) drive(op, z, 1'b1, 1'b1, O_TRAP);
`else
      exp_ret = exp_ret + 1'b1;
`endif
    end else begin
      drive(op, z, 1'b1, 1'b0, O_NONE);
      if (op == OP_BEQ) begin
        drive(op, z, 1'b1, z, O_BEQ_T);
        exp_ret = exp_ret + 1'b1;
      end else begin
        if (op == OP_RTYPE) drive(op, z, 1'b1, 1'b0, O_NONE);
        else                drive(op, z, 1'b1, 1'b1, O_EX_IMM);
        if ((op == OP_LD) || (op == OP_ST)) begin
          for (int i = 0; i < mw; i++)
            drive(op, z, 1'b0, 1'b1, (op == OP_ST) ? O_MEM_ST : O_MEM_LD);
          drive(op, z, 1'b1, 1'b1, (op == OP_ST) ? O_MEM_ST : O_MEM_LD);
        end
        if (op != OP_ST)
          drive(op, z, 1'b1, 1'b1,
                (op == OP_RTYPE) ? O_WB_R : ((op == OP_LD) ? O_WB_LD : O_WB_I));
        exp_ret = exp_ret + 1'b1;
      end
    end
  endtask

  // Asynchronous reset in the middle of a cycle, released just after a negedge.
  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_retired", {{(32-RW){1'b0}}, retired}, 32'd0);
    chk("async_halted", {31'd0, halted}, 32'd0);
    exp_ret = '0;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = OP_RTYPE; alu_zero = 1'b0; mem_ready = 1'b0; exp_ret = '0;

    fork
      // Monitor / scoreboard
      forever begin
        logic [EW-1:0] e;
        @(negedge clk);
        if (rst_n && w_ev) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output cyc=%0d got=%b ret=%0d", cyc, w_act, retired);
          end else begin
            e = exp_q.pop_front();
            if ({cyc, w_act, retired} !== e) begin
              n_fail++;
              $display("FAIL out_check got cyc=%0d out=%b ret=%0d exp cyc=%0d out=%b ret=%0d",
                       cyc, w_act, retired, e[EW-1 -: 32], e[RW +: 13], e[RW-1:0]);
            end
          end
        end
      end
      begin
        #200000;
        n_fail++;
        $display("FAIL timeout");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {19'd0, w_act}, 32'd0);
    chk("reset_retired", {{(32-RW){1'b0}}, retired}, 32'd0);
    chk("reset_state", {29'd0, dbg_state}, {29'd0, ST_FETCH});
    @(negedge clk); #1;
    rst_n = 1'b1;

    run_instr(OP_RTYPE, 1'b0, 0, 0);
    run_instr(OP_ADDI,  1'b0, 0, 0);
    run_instr(OP_LD,    1'b0, 0, 2);
    run_instr(OP_ST,    1'b0, 1, 1);
    run_instr(OP_BEQ,   1'b1, 0, 0);
    run_instr(OP_BEQ,   1'b0, 0, 0);
    for (int i = 0; i < 14; i++) run_instr(OP_J, 1'b0, 0, 0);
    run_instr(OP_LD,    1'b0, 0, 0);

    drive(OP_LD, 1'b0, 1'b0, 1'b1, O_FETCH_WAIT);
    pulse_reset();
    run_instr(6'h2A, 1'b0, 0, 0);
`ifndef MRISC_ILLEGAL_TRAP_EN
    run_instr(OP_RTYPE, 1'b0, 0, 0);
    drive(OP_RTYPE, 1'b0, 1'b0, 1'b1, O_FETCH_WAIT);
`endif
    pulse_reset();
    run_instr(OP_HALT, 1'b0, 0, 0);

    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
